// File: rtl/gemm_ctrl.sv
// gemm_ctrl: instruction-level sequencer in front of the gemm core.
// Accepts one VTA instruction at a time, pops its dependency tokens,
// launches the core (or handles FINISH / illegal opcodes), pushes tokens
// and retires the instruction.
//
// Handshake rule for every valid/ready pair: a transfer happens on the
// rising clk edge where valid and ready are both 1; a producer holds valid
// (and its payload) stable until that edge, and a consumer may raise ready
// independently of valid.
module gemm_ctrl #(
  parameter int INS_WIDTH = 128,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 insn_valid,
  output logic                 insn_ready,
  input  logic [INS_WIDTH-1:0] insn_data,
  input  logic                 l2g_dep_valid,
  output logic                 l2g_dep_ready,
  input  logic                 s2g_dep_valid,
  output logic                 s2g_dep_ready,
  output logic                 g2l_dep_valid,
  input  logic                 g2l_dep_ready,
  output logic                 g2s_dep_valid,
  input  logic                 g2s_dep_ready,
  output logic [INS_WIDTH-1:0] core_insn,
  output logic                 core_start,
  input  logic                 core_done,
  output logic                 finish,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] insn_count,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POP      = 3'd1,
    S_DISPATCH = 3'd2,
    S_EXEC     = 3'd3,
    S_PUSH     = 3'd4
  } state_t;

  localparam logic [2:0] OP_GEMM   = 3'd2;
  localparam logic [2:0] OP_FINISH = 3'd3;

  state_t               state;
  logic [INS_WIDTH-1:0] insn_r;
  logic [2:0]           opcode;
  logic                 is_gemm;
  logic                 is_finish;

  assign opcode    = insn_r[2:0];
  assign is_gemm   = (opcode == OP_GEMM);
  assign is_finish = (opcode == OP_FINISH);

  // Status views derived from the state register only.
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Sequencer FSM. The dep ready/valid registers double as the
  // "token still outstanding" flags: a pop/push is complete once its
  // register has been cleared by its handshake (or was never set).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      insn_r        <= '0;
      core_insn     <= '0;
      insn_ready    <= 1'b0;
      l2g_dep_ready <= 1'b0;
      s2g_dep_ready <= 1'b0;
      g2l_dep_valid <= 1'b0;
      g2s_dep_valid <= 1'b0;
      core_start    <= 1'b0;
      finish        <= 1'b0;
      err           <= 1'b0;
      insn_count    <= '0;
    end else begin
      // insn_r only changes on acceptance, so this copy is stable from
      // DISPATCH until the instruction retires.
      core_insn <= insn_r;
      case (state)
        S_IDLE: begin
          insn_ready <= 1'b1;
          if (insn_valid && insn_ready) begin
            insn_r        <= insn_data;
            insn_ready    <= 1'b0;
            l2g_dep_ready <= insn_data[3];
            s2g_dep_ready <= insn_data[4];
            state         <= S_POP;
          end
        end
        S_POP: begin
          if (l2g_dep_valid && l2g_dep_ready) l2g_dep_ready <= 1'b0;
          if (s2g_dep_valid && s2g_dep_ready) s2g_dep_ready <= 1'b0;
          // Move on only once every required token was taken in an earlier cycle.
          if (!l2g_dep_ready && !s2g_dep_ready) begin
            core_start <= is_gemm;
            finish     <= is_finish;
            state      <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          core_start <= 1'b0;
          finish     <= 1'b0;
          if (is_gemm) begin
            state <= S_EXEC;
          end else begin
            if (!is_finish) err <= 1'b1;
            g2l_dep_valid <= insn_r[5];
            g2s_dep_valid <= insn_r[6];
            state         <= S_PUSH;
          end
        end
        S_EXEC: begin
          if (core_done) begin
            g2l_dep_valid <= insn_r[5];
            g2s_dep_valid <= insn_r[6];
            state         <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (g2l_dep_valid && g2l_dep_ready) g2l_dep_valid <= 1'b0;
          if (g2s_dep_valid && g2s_dep_ready) g2s_dep_valid <= 1'b0;
          // Retire once both pushes were accepted in an earlier cycle.
          if (!g2l_dep_valid && !g2s_dep_valid) begin
            insn_count <= insn_count + 1'b1;
            insn_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_ctrl.sv
// tb_gemm_ctrl: self-checking bench for gemm_ctrl. Each instruction is
// driven cycle by cycle; expected event counts and cycle positions are
// computed from the instruction fields and the environment delays.
module tb_gemm_ctrl;

  localparam int INS_WIDTH = 128;
  localparam int CNT_WIDTH = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                 insn_valid;
  logic                 insn_ready;
  logic [INS_WIDTH-1:0] insn_data;
  logic                 l2g_dep_valid, l2g_dep_ready;
  logic                 s2g_dep_valid, s2g_dep_ready;
  logic                 g2l_dep_valid, g2l_dep_ready;
  logic                 g2s_dep_valid, g2s_dep_ready;
  logic [INS_WIDTH-1:0] core_insn;
  logic                 core_start;
  logic                 core_done;
  logic                 finish;
  logic                 busy;
  logic                 err;
  logic [CNT_WIDTH-1:0] insn_count;
  logic [2:0]           state_dbg;

  gemm_ctrl #(.INS_WIDTH(INS_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn_data    (insn_data),
    .l2g_dep_valid(l2g_dep_valid),
    .l2g_dep_ready(l2g_dep_ready),
    .s2g_dep_valid(s2g_dep_valid),
    .s2g_dep_ready(s2g_dep_ready),
    .g2l_dep_valid(g2l_dep_valid),
    .g2l_dep_ready(g2l_dep_ready),
    .g2s_dep_valid(g2s_dep_valid),
    .g2s_dep_ready(g2s_dep_ready),
    .core_insn    (core_insn),
    .core_start   (core_start),
    .core_done    (core_done),
    .finish       (finish),
    .busy         (busy),
    .err          (err),
    .insn_count   (insn_count),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [CNT_WIDTH-1:0] count_m = '0;  // expected retired count
  bit                   err_m   = 1'b0; // expected sticky error
  logic [INS_WIDTH-1:0] exp_q[$];       // instructions awaiting retirement

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_inputs();
    insn_valid    = 1'b0;
    l2g_dep_valid = 1'b0;
    s2g_dep_valid = 1'b0;
    g2l_dep_ready = 1'b0;
    g2s_dep_ready = 1'b0;
    core_done     = 1'b0;
  endtask

  // ---------------- driver: one full instruction ----------------
  // Cycle 0 is the acceptance cycle. Tokens from load/store become
  // available at cycles l2g_at/s2g_at (>=1); the core finishes
  // done_after cycles after its start pulse; push readies are withheld
  // for g2l_hold/g2s_hold cycles after the valid first appears.
  task automatic run_insn(input logic [INS_WIDTH-1:0] ins, input int l2g_at, input int s2g_at,
                          input int done_after, input int g2l_hold, input int g2s_hold,
                          input bit stray_done);
    logic [2:0] op;
    logic [INS_WIDTH-1:0] ref_ins;
    bit pop_p, pop_n, push_p, push_n, is_gemm, is_fin, is_ill;
    int d_exp, p_exp, hp, idle_exp, wait_n;
    int n_start, n_fin, n_l2g, n_s2g, n_g2l, n_g2s;
    int t_start, t_fin, t_idle, g2l_seen, g2s_seen;
    bit l2g_took, s2g_took, g2l_pend, g2s_pend, rdy_bad, hold_bad, cinsn_bad, ready_at_idle;

    exp_q.push_back(ins);
    op      = ins[2:0];
    pop_p   = ins[3];
    pop_n   = ins[4];
    push_p  = ins[5];
    push_n  = ins[6];
    is_gemm = (op == 3'd2);
    is_fin  = (op == 3'd3);
    is_ill  = !is_gemm && !is_fin;

    // Reference timing from the sequencing rules.
    d_exp = 2 + imax(pop_p ? l2g_at : 0, pop_n ? s2g_at : 0);
    p_exp = d_exp + (is_gemm ? done_after : 0) + 1;
    hp = -1;
    if (push_p) hp = imax(hp, p_exp + g2l_hold);
    if (push_n) hp = imax(hp, p_exp + g2s_hold);
    idle_exp = (hp < 0) ? p_exp + 1 : hp + 2;

    n_start = 0; n_fin = 0; n_l2g = 0; n_s2g = 0; n_g2l = 0; n_g2s = 0;
    t_start = -1; t_fin = -1; t_idle = -1; g2l_seen = 0; g2s_seen = 0;
    l2g_took = 0; s2g_took = 0; g2l_pend = 0; g2s_pend = 0;
    rdy_bad = 0; hold_bad = 0; cinsn_bad = 0; ready_at_idle = 0;

    @(negedge clk);
    insn_valid = 1'b1;
    insn_data  = ins;
    wait_n = 0;
    while (!insn_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("accept_ready", insn_ready, 1'b1);
    if (!insn_ready) begin
      clear_inputs();
      void'(exp_q.pop_front());
      return;
    end
    ref_ins = exp_q.pop_front();

    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        insn_valid = 1'b0;
        insn_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      // observe cycle k
      if (!busy) begin
        t_idle = k;
        ready_at_idle = insn_ready;
        break;
      end
      if (core_start) begin n_start++; t_start = k; end
      if (finish) begin n_fin++; t_fin = k; end
      if (l2g_took && l2g_dep_ready) rdy_bad = 1;
      if (s2g_took && s2g_dep_ready) rdy_bad = 1;
      if (g2l_pend && !g2l_dep_valid) hold_bad = 1;
      if (g2s_pend && !g2s_dep_valid) hold_bad = 1;
      if (k >= d_exp && core_insn !== ref_ins) cinsn_bad = 1;
      // drive cycle k
      l2g_dep_valid = (k >= l2g_at) && !l2g_took;
      if (l2g_dep_valid && l2g_dep_ready) begin n_l2g++; l2g_took = 1; end
      s2g_dep_valid = (k >= s2g_at) && !s2g_took;
      if (s2g_dep_valid && s2g_dep_ready) begin n_s2g++; s2g_took = 1; end
      core_done = (n_start > 0 && k == t_start + done_after) || (stray_done && k == 1);
      g2l_dep_ready = g2l_dep_valid && (g2l_seen >= g2l_hold);
      if (g2l_dep_valid && g2l_dep_ready) begin n_g2l++; g2l_pend = 0; end
      else if (g2l_dep_valid) begin g2l_pend = 1; g2l_seen++; end
      g2s_dep_ready = g2s_dep_valid && (g2s_seen >= g2s_hold);
      if (g2s_dep_valid && g2s_dep_ready) begin n_g2s++; g2s_pend = 0; end
      else if (g2s_dep_valid) begin g2s_pend = 1; g2s_seen++; end
    end
    clear_inputs();

    count_m = count_m + 1'b1;
    if (is_ill) err_m = 1'b1;

    check("retire_timeout", (t_idle >= 0), 1'b1);
    check("core_start_cnt", n_start, is_gemm ? 1 : 0);
    check("finish_cnt", n_fin, is_fin ? 1 : 0);
    if (is_gemm) check("start_cycle", t_start, d_exp);
    if (is_fin) check("finish_cycle", t_fin, d_exp);
    check("l2g_pops", n_l2g, pop_p);
    check("s2g_pops", n_s2g, pop_n);
    check("g2l_pushes", n_g2l, push_p);
    check("g2s_pushes", n_g2s, push_n);
    check("idle_cycle", t_idle, idle_exp);
    check("ready_at_idle", ready_at_idle, 1'b1);
    check("pop_ready_drop", rdy_bad, 1'b0);
    check("push_valid_hold", hold_bad, 1'b0);
    check("core_insn_stable", cinsn_bad, 1'b0);
    check("insn_count", insn_count, count_m);
    check("err_flag", err, err_m);
  endtask

  function automatic logic [INS_WIDTH-1:0] mk_insn(input logic [2:0] op, input logic [3:0] deps);
    logic [INS_WIDTH-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[2:0] = op;
    w[6:3] = deps;
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [INS_WIDTH-1:0] w;
    int wait_n;
    logic [2:0] op;

    clear_inputs();
    insn_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", insn_ready, 1'b0);
    check("rst_core_insn", core_insn, '0);
    check("rst_count", insn_count, '0);
    check("rst_err", err, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", insn_ready, 1'b1);

    // GEMM, no deps, done 5 cycles after start.
    run_insn(mk_insn(3'd2, 4'b0000), 1, 1, 5, 0, 0, 1'b0);
    // Both pops: load token at 3, store token at 6.
    run_insn(mk_insn(3'd2, 4'b0011), 3, 6, 2, 0, 0, 1'b0);
    // Both pushes, store queue stalls 4 cycles.
    run_insn(mk_insn(3'd2, 4'b1100), 1, 1, 3, 0, 4, 1'b0);
    // FINISH with pushes.
    run_insn(mk_insn(3'd3, 4'b1100), 1, 1, 1, 2, 1, 1'b0);
    // Illegal opcode, then a legal GEMM with a stray early core_done.
    run_insn(mk_insn(3'd5, 4'b0101), 2, 1, 1, 0, 1, 1'b0);
    run_insn(mk_insn(3'd2, 4'b0000), 1, 1, 4, 0, 0, 1'b1);

    // Randomised instructions.
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = 3'd2;
        2:       op = 3'd3;
        default: op = 3'($urandom_range(0, 7));
      endcase
      run_insn(mk_insn(op, 4'($urandom_range(0, 15))), $urandom_range(1, 6), $urandom_range(1, 6),
               $urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 4),
               1'($urandom_range(0, 1)));
    end

    // Reset while the core is executing.
    w = mk_insn(3'd2, 4'b1100);
    @(negedge clk);
    insn_valid = 1'b1;
    insn_data  = w;
    wait_n = 0;
    while (!insn_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
    @(negedge clk);
    insn_valid = 1'b0;
    wait_n = 0;
    while (!core_start && wait_n < 20) begin @(negedge clk); wait_n++; end
    check("mid_rst_start_seen", core_start, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    count_m = '0;
    err_m   = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", insn_ready, 1'b0);
    check("mid_rst_core_insn", core_insn, '0);
    check("mid_rst_count", insn_count, count_m);
    check("mid_rst_err", err, err_m);
    check("mid_rst_push", {g2l_dep_valid, g2s_dep_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_busy", busy, 1'b0);
    check("late_done_start", core_start, 1'b0);
    check("late_done_count", insn_count, count_m);
    run_insn(mk_insn(3'd2, 4'b1111), 2, 3, 2, 1, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
